addsub_pipe: RTL and testbench

- Parametrised, pipelined successor to the 32-bit combinational add/subtract unit.
- Splits a WIDTH-bit add/sub into NSTAGES = WIDTH/SEG_W carry-chained segments, with one register stage per segment. This bounds the worst-case carry delay to one segment per clock.
- Adds a valid/ready handshake, an optional signed-saturation mode, and zero/negative flags.
- Sits between the operand-fetch logic and the result writeback in the datapath.

---
 rtl/addsub_pkg.sv | 35 +++
 rtl/addsub_pipe_if.sv | 29 ++
 rtl/addsub_seg.sv | 20 ++
 rtl/addsub_pipe.sv | 128 ++++++++++++
 tb/tb_addsub_pipe.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared helpers for the segmented add/subtract pipeline: stage count,
// overflow detection and signed saturation constants.
package addsub_pkg;

  // Widest operand the saturation helpers can describe.
  localparam int MAX_W = 256;

  function automatic int nstages(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  // Signed overflow from the carry into and out of the MSB.
  function automatic logic ovf_carry(input logic cmsb, input logic cout);
    return cmsb ^ cout;
  endfunction

  function automatic logic [MAX_W-1:0] sat_pos(input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] sat_neg(input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe; master is the operand
// source plus result sink, slave is the pipeline itself.
interface addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             v;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, sub, sat, out_ready,
    input  in_ready, out_valid, sum, cout, v, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sub, sat, out_ready,
    output in_ready, out_valid, sum, cout, v, zero, neg
  );
endinterface

// File: rtl/addsub_seg.sv
// SEG_W-bit combinational segment adder; also reports the carry into its MSB
// so the top segment can derive signed overflow.
module addsub_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [SEG_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
  assign sum  = full[SEG_W-1:0];
  assign cout = full[SEG_W];
  // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of the sum.
  assign cmsb = sum[SEG_W-1] ^ a[SEG_W-1] ^ b[SEG_W-1];
endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract, one SEG_W-bit carry segment per stage;
// result after NSTAGES-1 edges past accept, whole pipe freezes on output stall.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input logic          clk,
  input logic          rst,
  addsub_pipe_if.slave bus
);
  localparam int NS = nstages(WIDTH, SEG_W);
  localparam int L  = NS - 1;

  localparam logic [MAX_W-1:0] SAT_POS_W = sat_pos(WIDTH);
  localparam logic [MAX_W-1:0] SAT_NEG_W = sat_neg(WIDTH);
  localparam logic [WIDTH-1:0] SAT_POS   = SAT_POS_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_NEG   = SAT_NEG_W[WIDTH-1:0];

  logic advance;

  // Stage registers; entry k is written by stage k.
  logic             st_vld [NS];
  logic             st_cy  [NS];
  logic             st_sat [NS];
  logic [WIDTH-1:0] st_a   [NS];
  logic [WIDTH-1:0] st_b   [NS];
  logic [WIDTH-1:0] st_ps  [NS];

  // Inputs presented to the adder of stage k.
  logic             vld_i  [NS];
  logic             cin_i  [NS];
  logic             sat_i  [NS];
  logic [WIDTH-1:0] a_i    [NS];
  logic [WIDTH-1:0] b_i    [NS];
  logic [WIDTH-1:0] ps_i   [NS];
  logic [WIDTH-1:0] ps_n   [NS];

  logic [SEG_W-1:0] seg_sum [NS];
  logic             seg_co  [NS];
  logic             seg_cm  [NS];

  logic             raw_v;
  logic [WIDTH-1:0] fin_sum;
  logic             out_v;
  logic             out_zero;
  logic             out_neg;

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < NS; k++) begin : g_st
    if (k == 0) begin : g_head
      assign vld_i[k] = bus.in_valid;
      assign a_i[k]   = bus.a;
      assign b_i[k]   = bus.b ^ {WIDTH{bus.sub}};
      assign cin_i[k] = bus.sub;
      assign sat_i[k] = bus.sat;
      assign ps_i[k]  = '0;
    end else begin : g_body
      assign vld_i[k] = st_vld[k-1];
      assign a_i[k]   = st_a[k-1];
      assign b_i[k]   = st_b[k-1];
      assign cin_i[k] = st_cy[k-1];
      assign sat_i[k] = st_sat[k-1];
      assign ps_i[k]  = st_ps[k-1];
    end

    // Operand skew keeps the segment due next in the low SEG_W bits.
    addsub_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a    (a_i[k][SEG_W-1:0]),
      .b    (b_i[k][SEG_W-1:0]),
      .cin  (cin_i[k]),
      .sum  (seg_sum[k]),
      .cout (seg_co[k]),
      .cmsb (seg_cm[k])
    );

    assign ps_n[k] = ps_i[k] | (WIDTH'(seg_sum[k]) << (k * SEG_W));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_vld[k] <= 1'b0;
        st_cy[k]  <= 1'b0;
        st_sat[k] <= 1'b0;
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_ps[k]  <= '0;
      end else if (advance) begin
        st_vld[k] <= vld_i[k];
        if (vld_i[k]) begin
          st_cy[k]  <= seg_co[k];
          st_sat[k] <= sat_i[k];
          st_a[k]   <= a_i[k] >> SEG_W;
          st_b[k]   <= b_i[k] >> SEG_W;
          st_ps[k]  <= (k == L) ? fin_sum : ps_n[k];
        end
      end
    end
  end

  // The last stage resolves overflow and clamps toward the sign of A.
  assign raw_v   = ovf_carry(seg_cm[L], seg_co[L]);
  assign fin_sum = (sat_i[L] && raw_v) ? (a_i[L][SEG_W-1] ? SAT_NEG : SAT_POS)
                                       : ps_n[L];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v    <= 1'b0;
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
    end else if (advance && vld_i[L]) begin
      out_v    <= raw_v;
      out_zero <= (fin_sum == '0);
      out_neg  <= fin_sum[WIDTH-1];
    end
  end

  assign bus.out_valid = st_vld[L];
  assign bus.sum       = st_ps[L];
  assign bus.cout      = st_cy[L];
  assign bus.v         = out_v;
  assign bus.zero      = out_zero;
  assign bus.neg       = out_neg;
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed and streaming checks of addsub_pipe at 32/8 (four stages) and
// 16/16 (single stage).
module tb_addsub_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(32)) b32 ();
  addsub_pipe_if #(.WIDTH(16)) b16 ();

  addsub_pipe #(.WIDTH(32), .SEG_W(8))  u_dut32 (.clk(clk), .rst(rst), .bus(b32));
  addsub_pipe #(.WIDTH(16), .SEG_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // {3'b0, out_valid, cout, v, zero, neg, sum}
  function automatic logic [39:0] obs(input bit w16);
    if (w16) return {3'b000, b16.out_valid, b16.cout, b16.v, b16.zero, b16.neg, 16'h0000, b16.sum};
    return {3'b000, b32.out_valid, b32.cout, b32.v, b32.zero, b32.neg, b32.sum};
  endfunction

  task automatic drive(input bit w16, input logic vld, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic sat);
    if (w16) begin
      b16.in_valid = vld; b16.a = a[15:0]; b16.b = b[15:0]; b16.sub = sub; b16.sat = sat;
    end else begin
      b32.in_valid = vld; b32.a = a; b32.b = b; b32.sub = sub; b32.sat = sat;
    end
  endtask

  task automatic idle(input bit w16);
    drive(w16, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
  endtask

  // {cout, v, zero, neg, sum}
  function automatic logic [35:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic sat);
    logic [31:0] bp;
    logic [32:0] full;
    logic [31:0] raw;
    logic [31:0] res;
    logic        ov;
    bp   = b ^ {32{sub}};
    full = {1'b0, a} + {1'b0, bp} + {32'd0, sub};
    raw  = full[31:0];
    ov   = (a[31] == bp[31]) && (raw[31] != a[31]);
    res  = (sat && ov) ? (a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : raw;
    return {full[32], ov, res == 32'd0, res[31], res};
  endfunction

  // One beat; ef = {cout, v, zero, neg}.
  task automatic vec(input bit w16, input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic sub, input logic sat, input logic [31:0] es, input logic [3:0] ef);
    int          lat;
    logic [39:0] r;
    lat = w16 ? 1 : 4;
    @(negedge clk);
    drive(w16, 1'b1, a, b, sub, sat);
    #1 check_eq({tag, "_in_ready"}, 40'(w16 ? b16.in_ready : b32.in_ready), 40'd1);
    @(posedge clk);
    #1 idle(w16);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      r = obs(w16);
      check_eq({tag, "_early"}, 40'(r[36]), 40'd0);
    end
    @(negedge clk);
    check_eq({tag, "_result"}, obs(w16), {3'b000, 1'b1, ef, (w16 ? {16'h0000, es[15:0]} : es)});
  endtask

  task automatic stream(input int nbeats, input int stall_len, input string tag);
    logic [31:0] va [16];
    logic [31:0] vb [16];
    logic        vs [16];
    logic        vt [16];
    logic [35:0] expq [$];
    logic [39:0] snap;
    logic [39:0] e;
    int          sent, got, cyc, stall_cnt;
    bit          stall_done, seen;
    sent = 0; got = 0; cyc = 0; stall_cnt = 0; seen = 1'b0; snap = '0;
    stall_done = (stall_len == 0);
    for (int i = 0; i < 16; i++) begin
      va[i] = $urandom; vb[i] = $urandom; vs[i] = 1'($urandom); vt[i] = 1'($urandom);
    end
    while (got < nbeats && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!stall_done && stall_cnt == 0 && b32.out_valid) begin
        stall_cnt = stall_len;
        snap = obs(1'b0);
      end
      b32.out_ready = (stall_cnt == 0);
      if (sent < nbeats) drive(1'b0, 1'b1, va[sent], vb[sent], vs[sent], vt[sent]);
      else idle(1'b0);
      #1;
      if (stall_cnt > 0) begin
        check_eq({tag, "_stall_in_ready"}, 40'(b32.in_ready), 40'd0);
        if (stall_cnt < stall_len) check_eq({tag, "_stall_hold"}, obs(1'b0), snap);
        stall_cnt--;
        if (stall_cnt == 0) stall_done = 1'b1;
      end else begin
        if (sent < nbeats) check_eq({tag, "_in_ready"}, 40'(b32.in_ready), 40'd1);
        if (seen) check_eq({tag, "_one_per_clk"}, 40'(b32.out_valid), 40'd1);
      end
      if (b32.in_valid && b32.in_ready) begin
        expq.push_back(model32(va[sent], vb[sent], vs[sent], vt[sent]));
        sent++;
      end
      if (b32.out_valid && b32.out_ready) begin
        if (expq.size() > 0) e = {3'b000, 1'b1, expq.pop_front()};
        else e = '1;
        check_eq({tag, "_data"}, obs(1'b0), e);
        got++;
        seen = 1'b1;
      end
    end
    b32.out_ready = 1'b1;
    idle(1'b0);
    check_eq({tag, "_count"}, 40'(got), 40'(nbeats));
    check_eq({tag, "_leftover"}, 40'(expq.size()), 40'd0);
    @(negedge clk);
    check_eq({tag, "_no_dup"}, 40'(b32.out_valid), 40'd0);
  endtask

  task automatic reset_mid(input bit w16, input string tag);
    int          lat;
    logic [39:0] r;
    lat = w16 ? 1 : 4;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      drive(w16, 1'b1, 32'h11 + i, 32'h22, 1'b0, 1'b0);
    end
    @(posedge clk);
    #1 idle(w16);
    r = obs(w16);
    check_eq({tag, "_pre_valid"}, 40'(r[36]), 40'd1);
    check_eq({tag, "_pre_sum"}, 40'(r[31:0]), 40'h33);
    #2 rst = 1'b1;
    #1 check_eq({tag, "_async_clear"}, obs(w16), 40'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      r = obs(w16);
      check_eq({tag, "_no_stale"}, 40'(r[36]), 40'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d comparisons so far", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle(1'b0);
    idle(1'b1);
    b32.out_ready = 1'b1;
    b16.out_ready = 1'b1;
    #1;
    check_eq("reset_state32", obs(1'b0), 40'd0);
    check_eq("reset_state16", obs(1'b1), 40'd0);
    check_eq("reset_in_ready", 40'(b32.in_ready), 40'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    vec(1'b0, "add_ovf",      32'h7B5E_4C6A, 32'h1CCD_A1E4, 1'b0, 1'b0, 32'h982B_EE4E, 4'b0101);
    vec(1'b0, "add_ovf_sat",  32'h7B5E_4C6A, 32'h1CCD_A1E4, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0100);
    vec(1'b0, "add_allones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 4'b1001);
    vec(1'b0, "sub_borrow",   32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'b0001);
    vec(1'b0, "sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 4'b1100);
    vec(1'b0, "sub_ovf_sat",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000, 4'b1101);
    vec(1'b0, "sub_zero",     32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 4'b1010);
    vec(1'b0, "sat_no_ovf",   32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0008, 4'b0000);

    stream(16, 0, "stream");
    stream(12, 5, "backpressure");

    reset_mid(1'b0, "rst32");
    vec(1'b0, "post_rst32",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 4'b0000);

    vec(1'b1, "w16_ovf",      32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_8000, 4'b0101);
    vec(1'b1, "w16_ovf_sat",  32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_7FFF, 4'b0100);
    vec(1'b1, "w16_sub",      32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_FFFE, 4'b0001);
    vec(1'b1, "w16_sub_sat",  32'h0000_8000, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_8000, 4'b1101);
    reset_mid(1'b1, "rst16");
    vec(1'b1, "post_rst16",   32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_0000, 4'b1010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
